// File: rtl/if_id_pipe.sv
// ---------------------------------------------------------------------------
// if_id_pipe -- IF/ID pipeline register stage with valid/ready handshake.
//
// Carries fetch bundles (LANES instructions plus their PC+4 link addresses)
// from IF to ID with one cycle of latency, in FIFO order.
//
// Build option:
//   IF_ID_PIPE_SKID_EN  defined   : 2-entry skid buffer (EMPTY/ONE/FULL);
//                                   ifready comes from registered state only,
//                                   so no combinational path idready->ifready.
//                       undefined : single register, ifready = idready || !idvalid.
//
// Ports:
//   CLK             in   rising-edge clock
//   RST             in   asynchronous active-high reset
//   ifW             in   IF offers a valid bundle
//   ifRST           in   synchronous flush (branch/jump redirect)
//   ifinstr         in   LANES*WORD_W fetched instructions, lane 0 low
//   ifJALjump_addr  in   LANES*WORD_W per-lane link addresses
//   ifready         out  stage accepts a bundle this cycle
//   idvalid         out  ID bundle valid
//   idready         in   ID consumes the bundle this cycle
//   idinstr         out  instructions to decode (zero when !idvalid)
//   idJALjump_addr  out  link addresses (zero when !idvalid)
//   idrsel1         out  LANES*5 per-lane instr[25:21]
//   idrsel2         out  LANES*5 per-lane instr[20:16]
// ---------------------------------------------------------------------------
module if_id_pipe #(
  parameter int LANES  = 1,
  parameter int WORD_W = 32
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    ifW,
  input  logic                    ifRST,
  input  logic [LANES*WORD_W-1:0] ifinstr,
  input  logic [LANES*WORD_W-1:0] ifJALjump_addr,
  output logic                    ifready,
  output logic                    idvalid,
  input  logic                    idready,
  output logic [LANES*WORD_W-1:0] idinstr,
  output logic [LANES*WORD_W-1:0] idJALjump_addr,
  output logic [LANES*5-1:0]      idrsel1,
  output logic [LANES*5-1:0]      idrsel2
);

  localparam int BW = LANES * WORD_W;

  logic          accept;
  logic          handoff;
  logic          head_valid;
  logic [BW-1:0] head_instr_q;
  logic [BW-1:0] head_link_q;

`ifdef IF_ID_PIPE_SKID_EN

  // state   | meaning
  // S_EMPTY | no bundle held
  // S_ONE   | head holds the bundle shown on id*
  // S_FULL  | head shown on id*, tail holds the next bundle
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } occ_e;

  occ_e          state_q;
  occ_e          state_d;
  logic [BW-1:0] tail_instr_q;
  logic [BW-1:0] tail_link_q;
  logic          ready_st;
  logic          valid_st;

  // state register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state logic; flush wins over any transfer
  always_comb begin
    state_d = state_q;
    if (ifRST) begin
      state_d = S_EMPTY;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (accept) state_d = S_ONE;
        end
        S_ONE: begin
          if (accept && !handoff)      state_d = S_FULL;
          else if (!accept && handoff) state_d = S_EMPTY;
        end
        S_FULL: begin
          if (handoff) state_d = S_ONE;
        end
        default: state_d = S_EMPTY;
      endcase
    end
  end

  // outputs decoded purely from the state register
  always_comb begin
    ready_st = 1'b1;
    valid_st = 1'b0;
    case (state_q)
      S_EMPTY: begin
        ready_st = 1'b1;
        valid_st = 1'b0;
      end
      S_ONE: begin
        ready_st = 1'b1;
        valid_st = 1'b1;
      end
      S_FULL: begin
        ready_st = 1'b0;
        valid_st = 1'b1;
      end
      default: begin
        ready_st = 1'b1;
        valid_st = 1'b0;
      end
    endcase
  end

  assign ifready    = ready_st;
  assign head_valid = valid_st;
  assign accept     = ifW && ready_st;
  assign handoff    = valid_st && idready;

  // Datapath. In ONE with accept and hand-off together the new bundle goes
  // straight to the head; the tail is only filled when the head stays put.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      head_instr_q <= '0;
      head_link_q  <= '0;
      tail_instr_q <= '0;
      tail_link_q  <= '0;
    end else if (ifRST) begin
      head_instr_q <= '0;
      head_link_q  <= '0;
      tail_instr_q <= '0;
      tail_link_q  <= '0;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (accept) begin
            head_instr_q <= ifinstr;
            head_link_q  <= ifJALjump_addr;
          end
        end
        S_ONE: begin
          if (accept && handoff) begin
            head_instr_q <= ifinstr;
            head_link_q  <= ifJALjump_addr;
          end else if (accept) begin
            tail_instr_q <= ifinstr;
            tail_link_q  <= ifJALjump_addr;
          end else if (handoff) begin
            head_instr_q <= '0;
            head_link_q  <= '0;
          end
        end
        S_FULL: begin
          if (handoff) begin
            head_instr_q <= tail_instr_q;
            head_link_q  <= tail_link_q;
            tail_instr_q <= '0;
            tail_link_q  <= '0;
          end
        end
        default: begin
          head_instr_q <= '0;
          head_link_q  <= '0;
          tail_instr_q <= '0;
          tail_link_q  <= '0;
        end
      endcase
    end
  end

`else

  logic valid_q;
  logic valid_d;

  // Single register: a full stage can still take a new bundle in the same
  // cycle ID drains it, hence the combinational idready term.
  assign ifready    = idready || !valid_q;
  assign head_valid = valid_q;
  assign accept     = ifW && ifready;
  assign handoff    = valid_q && idready;

  always_comb begin
    valid_d = valid_q;
    if (ifRST)        valid_d = 1'b0;
    else if (accept)  valid_d = 1'b1;
    else if (handoff) valid_d = 1'b0;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      valid_q      <= 1'b0;
      head_instr_q <= '0;
      head_link_q  <= '0;
    end else begin
      valid_q <= valid_d;
      if (ifRST) begin
        head_instr_q <= '0;
        head_link_q  <= '0;
      end else if (accept) begin
        head_instr_q <= ifinstr;
        head_link_q  <= ifJALjump_addr;
      end
    end
  end

`endif

  // Outputs read as a NOP bundle whenever nothing valid is held.
  assign idvalid        = head_valid;
  assign idinstr        = head_valid ? head_instr_q : '0;
  assign idJALjump_addr = head_valid ? head_link_q  : '0;

  for (genvar l = 0; l < LANES; l++) begin : g_rsel
    assign idrsel1[l*5 +: 5] = idinstr[l*WORD_W + 21 +: 5];
    assign idrsel2[l*5 +: 5] = idinstr[l*WORD_W + 16 +: 5];
  end

endmodule

// File: tb/tb_if_id_pipe.sv
module tb_if_id_pipe;

  logic        CLK = 1'b0;
  logic        RST;
  logic        ifW;
  logic        ifRST;
  logic        idready;
  logic [31:0] ifinstr;
  logic [31:0] ifJALjump_addr;
  logic        ifready;
  logic        idvalid;
  logic [31:0] idinstr;
  logic [31:0] idJALjump_addr;
  logic [4:0]  idrsel1;
  logic [4:0]  idrsel2;

  logic [63:0] ifinstr2;
  logic [63:0] ifJALjump_addr2;
  logic        ifready2;
  logic        idvalid2;
  logic [63:0] idinstr2;
  logic [63:0] idJALjump_addr2;
  logic [9:0]  idrsel1_2;
  logic [9:0]  idrsel2_2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  if_id_pipe #(.LANES(1), .WORD_W(32)) dut (
    .CLK(CLK), .RST(RST), .ifW(ifW), .ifRST(ifRST),
    .ifinstr(ifinstr), .ifJALjump_addr(ifJALjump_addr),
    .ifready(ifready), .idvalid(idvalid), .idready(idready),
    .idinstr(idinstr), .idJALjump_addr(idJALjump_addr),
    .idrsel1(idrsel1), .idrsel2(idrsel2)
  );

  if_id_pipe #(.LANES(2), .WORD_W(32)) dut2 (
    .CLK(CLK), .RST(RST), .ifW(ifW), .ifRST(ifRST),
    .ifinstr(ifinstr2), .ifJALjump_addr(ifJALjump_addr2),
    .ifready(ifready2), .idvalid(idvalid2), .idready(idready),
    .idinstr(idinstr2), .idJALjump_addr(idJALjump_addr2),
    .idrsel1(idrsel1_2), .idrsel2(idrsel2_2)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drain();
    ifW = 1'b0; ifRST = 1'b0; idready = 1'b1;
    tick(); tick(); tick();
    idready = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1; ifW = 1'b0; ifRST = 1'b0; idready = 1'b0;
    ifinstr = '0; ifJALjump_addr = '0; ifinstr2 = '0; ifJALjump_addr2 = '0;
    tick(); tick();
    n_cmp++; if (idvalid !== 1'b0) begin n_err++; $display("FAIL reset_idvalid got %b want 0", idvalid); end
    n_cmp++; if (idinstr !== 32'h0) begin n_err++; $display("FAIL reset_idinstr got %h want 0", idinstr); end
    n_cmp++; if (ifready !== 1'b1) begin n_err++; $display("FAIL reset_ifready got %b want 1", ifready); end
    RST = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    ifW = 1'b1; idready = 1'b0;
    ifinstr = 32'h8C220004; ifJALjump_addr = 32'h00000044;
    tick();
    ifW = 1'b0;
    n_cmp++; if (idvalid !== 1'b1) begin n_err++; $display("FAIL basic_idvalid got %b want 1", idvalid); end
    n_cmp++; if (idinstr !== 32'h8C220004) begin n_err++; $display("FAIL basic_idinstr got %h want 8c220004", idinstr); end
    n_cmp++; if (idrsel1 !== 5'd1) begin n_err++; $display("FAIL basic_rsel1 got %0d want 1", idrsel1); end
    n_cmp++; if (idrsel2 !== 5'd2) begin n_err++; $display("FAIL basic_rsel2 got %0d want 2", idrsel2); end
    n_cmp++; if (idJALjump_addr !== 32'h44) begin n_err++; $display("FAIL basic_link got %h want 44", idJALjump_addr); end
    idready = 1'b1;
    tick();
    idready = 1'b0;
    n_cmp++; if (idvalid !== 1'b0) begin n_err++; $display("FAIL basic_drained_valid got %b want 0", idvalid); end
    n_cmp++; if (idinstr !== 32'h0 || idrsel1 !== 5'd0) begin n_err++; $display("FAIL basic_nop got %h/%0d want 0/0", idinstr, idrsel1); end
  endtask

  task automatic test_stream();
    logic [31:0] v;
    idready = 1'b1; ifW = 1'b1;
    for (int i = 0; i < 6; i++) begin
      v = 32'h1000_0000 + 32'(i * 3);
      ifinstr = v; ifJALjump_addr = 32'h100 + 32'(i * 4);
      #1;
      n_cmp++; if (ifready !== 1'b1) begin n_err++; $display("FAIL stream_ifready[%0d] got %b want 1", i, ifready); end
      tick();
      n_cmp++; if (idvalid !== 1'b1 || idinstr !== v) begin n_err++; $display("FAIL stream_out[%0d] got %b/%h want 1/%h", i, idvalid, idinstr, v); end
    end
    drain();
  endtask

`ifndef IF_ID_PIPE_SKID_EN
  task automatic test_hold();
    idready = 1'b0; ifW = 1'b1;
    ifinstr = 32'hAAAA_0001; ifJALjump_addr = 32'h8;
    tick();
    n_cmp++; if (ifready !== 1'b0) begin n_err++; $display("FAIL hold_ifready_full got %b want 0", ifready); end
    ifinstr = 32'hBBBB_0002; ifJALjump_addr = 32'hC;
    tick();
    n_cmp++; if (idinstr !== 32'hAAAA_0001 || idJALjump_addr !== 32'h8) begin n_err++; $display("FAIL hold_stable got %h/%h want aaaa0001/8", idinstr, idJALjump_addr); end
    idready = 1'b1;
    #1;
    n_cmp++; if (ifready !== 1'b1) begin n_err++; $display("FAIL hold_ifready_comb got %b want 1", ifready); end
    tick();
    ifW = 1'b0;
    n_cmp++; if (idvalid !== 1'b1 || idinstr !== 32'hBBBB_0002) begin n_err++; $display("FAIL hold_next got %b/%h want 1/bbbb0002", idvalid, idinstr); end
    tick();
    n_cmp++; if (idvalid !== 1'b0) begin n_err++; $display("FAIL hold_empty got %b want 0", idvalid); end
    idready = 1'b0;
  endtask
`else
  task automatic test_skid();
    idready = 1'b0; ifW = 1'b1;
    ifinstr = 32'hA; ifJALjump_addr = 32'h1A;
    tick();
    n_cmp++; if (idinstr !== 32'hA || ifready !== 1'b1) begin n_err++; $display("FAIL skid_A got %h/%b want a/1", idinstr, ifready); end
    ifinstr = 32'hB; ifJALjump_addr = 32'h1B;
    tick();
    n_cmp++; if (idinstr !== 32'hA || ifready !== 1'b0) begin n_err++; $display("FAIL skid_full got %h/%b want a/0", idinstr, ifready); end
    ifinstr = 32'hC; ifJALjump_addr = 32'h1C;
    tick();
    n_cmp++; if (idinstr !== 32'hA || ifready !== 1'b0) begin n_err++; $display("FAIL skid_Cheld got %h/%b want a/0", idinstr, ifready); end
    idready = 1'b1;
    #1;
    n_cmp++; if (ifready !== 1'b0) begin n_err++; $display("FAIL skid_no_comb got %b want 0", ifready); end
    tick();
    n_cmp++; if (idvalid !== 1'b1 || idinstr !== 32'hB || ifready !== 1'b1) begin n_err++; $display("FAIL skid_B got %b/%h/%b want 1/b/1", idvalid, idinstr, ifready); end
    tick();
    ifW = 1'b0;
    n_cmp++; if (idvalid !== 1'b1 || idinstr !== 32'hC || idJALjump_addr !== 32'h1C) begin n_err++; $display("FAIL skid_C got %b/%h/%h want 1/c/1c", idvalid, idinstr, idJALjump_addr); end
    tick();
    n_cmp++; if (idvalid !== 1'b0) begin n_err++; $display("FAIL skid_empty got %b want 0", idvalid); end
    idready = 1'b0;
  endtask
`endif

  task automatic test_flush();
    idready = 1'b0; ifW = 1'b1;
    ifinstr = 32'h0000_00F1;
    tick();
    ifinstr = 32'h0000_00F2;
    tick();
    ifRST = 1'b1; ifinstr = 32'h0000_00DD;
    tick();
    ifRST = 1'b0; ifW = 1'b0;
    n_cmp++; if (idvalid !== 1'b0 || idinstr !== 32'h0) begin n_err++; $display("FAIL flush_out got %b/%h want 0/0", idvalid, idinstr); end
    n_cmp++; if (ifready !== 1'b1) begin n_err++; $display("FAIL flush_ifready got %b want 1", ifready); end
    idready = 1'b1;
    tick();
    n_cmp++; if (idvalid !== 1'b0) begin n_err++; $display("FAIL flush_D_dropped got %b/%h want 0", idvalid, idinstr); end
    idready = 1'b0;
  endtask

  task automatic test_reset_mid();
    idready = 1'b0; ifW = 1'b1;
    ifinstr = 32'h0000_0777;
    tick();
    #2 RST = 1'b1;
    #1;
    n_cmp++; if (idvalid !== 1'b0 || idinstr !== 32'h0) begin n_err++; $display("FAIL rstmid_async got %b/%h want 0/0", idvalid, idinstr); end
    tick();
    n_cmp++; if (idvalid !== 1'b0 || idinstr !== 32'h0 || ifready !== 1'b1) begin n_err++; $display("FAIL rstmid_edge got %b/%h/%b want 0/0/1", idvalid, idinstr, ifready); end
    RST = 1'b0;
    ifinstr = 32'h0000_0EEE;
    tick();
    ifW = 1'b0;
    n_cmp++; if (idvalid !== 1'b1 || idinstr !== 32'h0000_0EEE) begin n_err++; $display("FAIL rstmid_first got %b/%h want 1/00000eee", idvalid, idinstr); end
    drain();
  endtask

  task automatic test_lanes2();
    idready = 1'b0; ifW = 1'b1;
    ifinstr2 = {32'h00430820, 32'h8C220004};
    ifJALjump_addr2 = {32'h48, 32'h44};
    tick();
    ifW = 1'b0;
    n_cmp++; if (idvalid2 !== 1'b1 || idinstr2 !== 64'h00430820_8C220004) begin n_err++; $display("FAIL lanes2_instr got %b/%h", idvalid2, idinstr2); end
    n_cmp++; if (idrsel1_2 !== {5'd2, 5'd1}) begin n_err++; $display("FAIL lanes2_rsel1 got %h want %h", idrsel1_2, {5'd2, 5'd1}); end
    n_cmp++; if (idrsel2_2 !== {5'd3, 5'd2}) begin n_err++; $display("FAIL lanes2_rsel2 got %h want %h", idrsel2_2, {5'd3, 5'd2}); end
    n_cmp++; if (idJALjump_addr2 !== 64'h00000048_00000044) begin n_err++; $display("FAIL lanes2_link got %h", idJALjump_addr2); end
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_basic();
    test_stream();
`ifndef IF_ID_PIPE_SKID_EN
    test_hold();
`else
    test_skid();
`endif
    test_flush();
    test_reset_mid();
    test_lanes2();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/if_id_pipe.md
IF_ID_PIPE -- requirements
Module: if_id_pipe

Interface
REQ-001 SHALL have parameter LANES, default 1, instructions fetched per cycle (1 or 2).
REQ-002 SHALL have parameter WORD_W, default 32, instruction/address width in bits.
REQ-003 SHALL have port CLK  input  1  rising-edge clock.
REQ-004 SHALL have port RST  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port ifW  input  1  IF presents a valid fetch bundle (in_valid).
REQ-006 SHALL have port ifRST  input  1  synchronous flush (branch/jump redirect).
REQ-007 SHALL have port ifinstr  input  LANES*WORD_W  fetched instructions; lane 0 in the low bits.
REQ-008 SHALL have port ifJALjump_addr  input  LANES*WORD_W  per-lane PC+4 link address.
REQ-009 SHALL have port ifready  output  1  stage accepts a bundle this cycle.
REQ-010 SHALL have port idvalid  output  1  ID output bundle valid.
REQ-011 SHALL have port idready  input  1  ID consumes the bundle this cycle.
REQ-012 SHALL have port idinstr  output  LANES*WORD_W  instructions to decode.
REQ-013 SHALL have port idJALjump_addr  output  LANES*WORD_W  link addresses to decode.
REQ-014 SHALL have port idrsel1  output  LANES*5  per-lane instr[25:21].
REQ-015 SHALL have port idrsel2  output  LANES*5  per-lane instr[20:16].

Function
REQ-016 SHALL accept a bundle when ifW && ifready, and hand off a bundle when idvalid && idready.
REQ-017 SHALL give 1-cycle latency: a bundle accepted at edge N is on the id* outputs, with idvalid=1, after edge N.
REQ-018 SHALL keep bundles in FIFO order; none duplicated or dropped except by flush or reset.
REQ-019 SHALL hold id* outputs stable while idvalid=1 and idready=0.
REQ-020 SHALL drive idinstr, idJALjump_addr, idrsel1 and idrsel2 to all-zero (MIPS NOP) whenever idvalid=0.
REQ-021 SHALL derive idrsel1/idrsel2 combinationally from the registered head instruction of each lane.
REQ-022 SHALL, when ifRST=1 at an edge, empty all storage and force idvalid=0, discarding any same-cycle input; ifRST overrides ifW and idready.
REQ-023 SHALL allow a simultaneous accept and hand-off in one cycle without changing occupancy.
REQ-024 SHALL treat ifW while ifready=0 as no transfer; IF holds its data.

Reset
REQ-025 SHALL, while RST=1, asynchronously clear occupancy to 0 and all stored data to 0.
REQ-026 SHALL, while RST=1, drive idvalid=0 and all id* data to 0.
REQ-027 SHALL, when RST asserts mid-transfer, lose all in-flight bundles; the first accept after release lands in an empty stage.

Configuration
REQ-028 SHALL recognise macro IF_ID_PIPE_SKID_EN.
REQ-029 SHALL, with IF_ID_PIPE_SKID_EN defined, hold a 2-entry skid buffer with occupancy states EMPTY, ONE and FULL.
REQ-030 SHALL, in skid mode, move EMPTY->ONE on accept, ONE->FULL on accept without hand-off, FULL->ONE on hand-off, and ONE->EMPTY on hand-off without accept.
REQ-031 SHALL, in skid mode, drive ifready registered (ifready = state!=FULL), with no combinational path from idready.
REQ-032 SHALL, without IF_ID_PIPE_SKID_EN, hold a single register with ifready = idready || !idvalid (combinational).

Verification
REQ-033 SHALL cover: RST pulse mid-stream -> idvalid=0, idinstr=0 and ifready=1 on the next edge.
REQ-034 SHALL cover: accept instr 0x8C220004 with link 0x00000044 -> next cycle idvalid=1, idinstr=0x8C220004, idrsel1=1, idrsel2=2, idJALjump_addr=0x44.
REQ-035 SHALL cover: skid mode, idready=0, three bundles A,B,C offered -> A and B accepted, ifready=0 from the third cycle, C held; idready=1 -> A, B, C emitted in order.
REQ-036 SHALL cover: ifRST=1 while FULL and ifW=1 with D -> next cycle idvalid=0, D not emitted, ifready=1.
REQ-037 SHALL cover: LANES=2, bundle {0x00430820, 0x8C220004} -> idrsel1={2,1}, idrsel2={3,2} (lane1,lane0).
REQ-038 SHALL cover: non-skid mode, steady idready=1 with ifW=1 every cycle -> one bundle out per cycle and ifready constantly 1.
